// File: rtl/cmd_dispatcher.sv
// Command-issue front end: pops decoded register commands, holds writes that would
// disturb in-flight rendering, issues single-cycle strobes and returns read data.
module cmd_dispatcher #(
    parameter int unsigned STALL_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty,
    input  logic [71:0] fifo_rdata,
    output logic        fifo_rd_en,
    output logic        cmd_valid,
    output logic        cmd_rw,
    output logic [6:0]  cmd_addr,
    output logic [63:0] cmd_wdata,
    input  logic [63:0] cmd_rdata,
    input  logic        tri_ready,
    input  logic        gpu_busy,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    input  logic        rd_ready,
    output logic        stall_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ISSUE   = 2'd2;
    localparam logic [1:0] ST_RD_HOLD = 2'd3;

    localparam logic [6:0]  ADDR_VERTEX = 7'h02;
    localparam logic [15:0] STALL_LAST  = 16'(STALL_TIMEOUT - 1);
    localparam logic [15:0] STALL_MAX   = 16'hFFFF;

    // Registers that must not change while the rasterizer/clear engine is active.
    function automatic logic is_barrier(input logic [6:0] addr);
        logic hit;
        case (addr)
            7'h04, 7'h05, 7'h06, 7'h08, 7'h0A, 7'h0B, 7'h31: hit = 1'b1;
            default:                                         hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic gate_open(input logic [71:0] cmd,
                                       input logic        tri_rdy,
                                       input logic        busy);
        logic ok;
        if (cmd[71]) begin
            ok = 1'b1;
        end else if (cmd[70:64] == ADDR_VERTEX) begin
            ok = tri_rdy;
        end else if (is_barrier(cmd[70:64])) begin
            ok = ~busy;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    logic [1:0]  state_q,     state_d;
    logic [71:0] hold_q,      hold_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        rd_valid_q,  rd_valid_d;
    logic [63:0] rd_data_q,   rd_data_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_err_q, stall_err_d;
    logic        pop_s;
    logic        gate_s;

    assign gate_s = gate_open(hold_q, tri_ready, gpu_busy);

    // Next-state logic: dispatch sequencing, pops, readback capture and watchdog.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cmd_valid_d = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_s       = 1'b1;
                    hold_d      = fifo_rdata;
                    stall_cnt_d = 16'd0;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (gate_s) begin
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                    if (stall_cnt_q == STALL_LAST) begin
                        stall_err_d = 1'b1;
                    end else begin
                        stall_err_d = stall_err_q;
                    end
                end
            end
            ST_ISSUE: begin
                if (hold_q[71]) begin
                    rd_data_d  = cmd_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = ST_RD_HOLD;
                end else if (!fifo_empty) begin
                    // Chain the next command straight into WAIT: two cycles per write.
                    pop_s       = 1'b1;
                    hold_d      = fifo_rdata;
                    stall_cnt_d = 16'd0;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_RD_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any command already popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 72'd0;
            cmd_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 64'd0;
            stall_cnt_q <= 16'd0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cmd_valid_q <= cmd_valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Pop is masked during reset so the FIFO never loses an entry the core ignores.
    assign fifo_rd_en = pop_s & rst_n;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_rw     = hold_q[71];
    assign cmd_addr   = hold_q[70:64];
    assign cmd_wdata  = hold_q[63:0];
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios plus random traffic, all checked
// against a transaction-level model of pops, gated issue, readback and watchdog.
module tb_cmd_dispatcher;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [71:0] fifo_rdata;
    logic        fifo_rd_en;
    logic        cmd_valid;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic [63:0] cmd_rdata;
    logic        tri_ready;
    logic        gpu_busy;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_ready;
    logic        stall_err;

    int n_cmp = 0;
    int n_bad = 0;

    cmd_dispatcher #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_rdata(cmd_rdata), .tri_ready(tri_ready), .gpu_busy(gpu_busy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register file: fixed per-address contents, 0x7F holds 0x6702.
    function automatic logic [63:0] rf(input logic [6:0] a);
        if (a == 7'h7F) return 64'h6702;
        return {16'hC0DE, 41'd0, a};
    endfunction

    assign cmd_rdata = rf(cmd_addr);

    function automatic bit may_issue(input logic [71:0] c, input logic tr, input logic gb);
        logic [6:0] a;
        a = c[70:64];
        if (c[71]) return 1'b1;
        if (a == 7'h02) return tr;
        if (a inside {7'h04, 7'h05, 7'h06, 7'h08, 7'h0A, 7'h0B, 7'h31}) return !gb;
        return 1'b1;
    endfunction

    // Command FIFO (show-ahead)
    logic [71:0] fq[$];
    bit          do_pop = 1'b0;

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() == 0) ? 72'd0 : fq[0];
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [63:0] d);
        fq.push_back({rw, a, d});
        refresh();
    endtask

    always @(posedge clk) begin
        #1;
        if (do_pop && fq.size() > 0) void'(fq.pop_front());
        do_pop = 1'b0;
        refresh();
    end

    // Reference model: one popped command pending, one issue due, one readback owed.
    bit          m_pend = 1'b0, m_due = 1'b0, m_rb = 1'b0, m_err = 1'b0;
    logic [71:0] m_cmd, m_icmd;
    logic [63:0] m_rbd;
    int          m_stall = 0;
    int          n_issue = 0;
    logic [6:0]  last_addr = 7'd0;

    always @(negedge clk) begin
        bit exp_pop, nxt_due, nxt_rb;
        if (!rst_n) begin
            check_eq("rst_cmd_valid", cmd_valid, 1'b0);
            check_eq("rst_fifo_rd_en", fifo_rd_en, 1'b0);
            check_eq("rst_rd_valid", rd_valid, 1'b0);
            check_eq("rst_rd_data", rd_data, 64'd0);
            check_eq("rst_stall_err", stall_err, 1'b0);
            check_eq("rst_cmd_fields", {cmd_rw, cmd_addr, cmd_wdata}, 72'd0);
            m_pend = 1'b0; m_due = 1'b0; m_rb = 1'b0; m_err = 1'b0; m_stall = 0;
            do_pop = 1'b0;
        end else begin
            exp_pop = !fifo_empty && ((!m_pend && !m_due && !m_rb) || (m_due && !m_icmd[71]));
            check_eq("cmd_valid", cmd_valid, m_due);
            if (m_due) begin
                check_eq("cmd_fields", {cmd_rw, cmd_addr, cmd_wdata}, m_icmd);
                n_issue++;
                last_addr = cmd_addr;
            end
            check_eq("rd_valid", rd_valid, m_rb);
            if (m_rb) check_eq("rd_data", rd_data, m_rbd);
            check_eq("stall_err", stall_err, m_err);
            check_eq("fifo_rd_en", fifo_rd_en, exp_pop);

            nxt_rb = m_rb;
            if (m_rb && rd_ready) nxt_rb = 1'b0;
            if (m_due && m_icmd[71]) begin
                nxt_rb = 1'b1;
                m_rbd  = rf(m_icmd[70:64]);
            end
            nxt_due = 1'b0;
            if (m_pend) begin
                if (may_issue(m_cmd, tri_ready, gpu_busy)) begin
                    nxt_due = 1'b1;
                    m_icmd  = m_cmd;
                    m_pend  = 1'b0;
                end else begin
                    m_stall++;
                    if (m_stall >= TO) m_err = 1'b1;
                end
            end
            if (exp_pop) begin
                m_pend  = 1'b1;
                m_cmd   = fifo_rdata;
                m_stall = 0;
            end
            m_due  = nxt_due;
            m_rb   = nxt_rb;
            do_pop = fifo_rd_en;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            idle = (fq.size() == 0) && !m_pend && !m_due && !m_rb;
            if (idle) break;
            step(1);
        end
        check_eq(tag, idle, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; tri_ready = 1'b0; gpu_busy = 1'b0; rd_ready = 1'b0;
        refresh();
        step(3);
        rst_n = 1'b1;
        step(1);

        // Three VERTEX writes back to back
        tri_ready = 1'b1; gpu_busy = 1'b1;
        base = n_issue;
        push(1'b0, 7'h02, 64'h1111_2222_3333_4444);
        push(1'b0, 7'h02, 64'h5555_6666_7777_8888);
        push(1'b0, 7'h02, 64'h9999_AAAA_BBBB_CCCC);
        wait_idle("vtx_idle", 40);
        check_eq("vtx_count", n_issue - base, 3);

        // Barrier write held by gpu_busy
        base = n_issue;
        push(1'b0, 7'h08, 64'h0010_0000);
        step(20);
        check_eq("barrier_held", n_issue - base, 0);
        gpu_busy = 1'b0;
        wait_idle("barrier_idle", 20);
        check_eq("barrier_count", n_issue - base, 1);

        // Read with delayed readback acceptance; next entry must stay queued
        rd_ready = 1'b0;
        push(1'b1, 7'h7F, 64'd0);
        push(1'b0, 7'h20, 64'hABCD);
        step(5);
        check_eq("rd_hold_valid", rd_valid, 1'b1);
        check_eq("rd_hold_data", rd_data, 64'h6702);
        check_eq("rd_hold_nopop", fifo_rd_en, 1'b0);
        step(3);
        rd_ready = 1'b1;
        wait_idle("read_idle", 20);

        // Watchdog
        tri_ready = 1'b0;
        push(1'b0, 7'h02, 64'hDEAD_BEEF);
        step(12);
        check_eq("wd_set", stall_err, 1'b1);
        tri_ready = 1'b1;
        wait_idle("wd_idle", 20);
        check_eq("wd_sticky", stall_err, 1'b1);

        // Clear write ahead of a read: read must wait behind it
        do_reset(2);
        gpu_busy = 1'b1;
        base = n_issue;
        push(1'b0, 7'h0B, 64'h1);
        push(1'b1, 7'h10, 64'd0);
        step(10);
        check_eq("order_blocked", n_issue - base, 0);
        gpu_busy = 1'b0;
        wait_idle("order_idle", 30);
        check_eq("order_count", n_issue - base, 2);

        // Reset while a write sits in WAIT
        gpu_busy = 1'b1;
        push(1'b0, 7'h08, 64'h77);
        push(1'b0, 7'h20, 64'h88);
        step(4);
        base = n_issue;
        do_reset(2);
        wait_idle("rstwait_idle", 30);
        check_eq("rstwait_count", n_issue - base, 1);
        check_eq("rstwait_addr", last_addr, 7'h20);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tri_ready = ($urandom_range(0, 3) != 0);
            gpu_busy  = ($urandom_range(0, 2) == 0);
            rd_ready  = ($urandom_range(0, 1) == 1);
            rst_n     = ($urandom_range(0, 499) != 0);
            if (fq.size() < 8 && $urandom_range(0, 2) == 0) begin
                logic [6:0] a;
                case ($urandom_range(0, 5))
                    0:       a = 7'h02;
                    1:       a = 7'h0B;
                    2:       a = 7'h31;
                    3:       a = 7'($urandom);
                    4:       a = 7'h7F;
                    default: a = 7'h10;
                endcase
                push($urandom_range(0, 3) == 0, a, {$urandom, $urandom});
            end
            step(1);
        end
        rst_n = 1'b1; tri_ready = 1'b1; gpu_busy = 1'b0; rd_ready = 1'b1;
        wait_idle("rand_idle", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
